// File: rtl/minimig_volume_scheduler_if.sv
// Frame bus between the audio sources/mixer and the shared-multiplier volume scaler.
// The master drives strobe, samples and volumes; the slave returns scaled samples and status pulses.
interface minimig_volume_scheduler_if #(
  parameter int NCH = 5,
  parameter int SW  = 16,
  parameter int VW  = 8
);
  logic              sample_strobe;
  logic [NCH*SW-1:0] sample_in;
  logic [NCH*VW-1:0] vol_in;
  logic [NCH*SW-1:0] sample_out;
  logic              out_valid;
  logic              busy;
  logic              overflow;
  logic              missed;

  modport master (
    output sample_strobe, sample_in, vol_in,
    input  sample_out, out_valid, busy, overflow, missed
  );

  modport slave (
    input  sample_strobe, sample_in, vol_in,
    output sample_out, out_valid, busy, overflow, missed
  );
endinterface

// File: rtl/minimig_volume_scheduler.sv
// Per-frame volume scaler: snapshots NCH samples/volumes on a strobe, scales them one per
// clock through a single signed multiplier, saturates, and publishes the whole frame at once.
module minimig_volume_scheduler #(
  parameter int NCH = 5,
  parameter int SW  = 16,
  parameter int VW  = 8
) (
  input  logic clk,
  input  logic rst_n,
  minimig_volume_scheduler_if.slave bus
);
  localparam int PW = SW + VW + 1;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SH = VW - 1;  // volume 2^(VW-1) is unity gain
  localparam logic signed [PW-1:0] SMAX = {{(PW-SW+1){1'b0}}, {(SW-1){1'b1}}};
  localparam logic signed [PW-1:0] SMIN = {{(PW-SW+1){1'b1}}, {(SW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          ch_q, ch_d;
  logic [CW-1:0]          pch_q, pch_d;
  logic [NCH-1:0][SW-1:0] shadow_s_q, shadow_s_d;
  logic [NCH-1:0][VW-1:0] shadow_v_q, shadow_v_d;
  logic [NCH-1:0][SW-1:0] result_q, result_d;
  logic [NCH-1:0][SW-1:0] sample_out_q, sample_out_d;
  logic signed [PW-1:0]   prod_q, prod_d;
  logic                   wb_vld_q, wb_vld_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;
  logic                   overflow_q, overflow_d;
  logic                   missed_q, missed_d;

  logic signed [PW-1:0]   mul_a, mul_b, scaled;
  logic [SW-1:0]          sat;
  logic                   clip;

  // Writeback stage: arithmetic shift floors toward -inf, then clamp to SW bits.
  always_comb begin
    scaled = prod_q >>> SH;
    clip   = 1'b0;
    sat    = scaled[SW-1:0];
    if (scaled > SMAX) begin
      sat  = {1'b0, {(SW-1){1'b1}}};
      clip = 1'b1;
    end else if (scaled < SMIN) begin
      sat  = {1'b1, {(SW-1){1'b0}}};
      clip = 1'b1;
    end
  end

  always_comb begin
    mul_a = PW'($signed(shadow_s_q[ch_q]));
    mul_b = PW'($signed({1'b0, shadow_v_q[ch_q]}));
  end

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    pch_d        = pch_q;
    shadow_s_d   = shadow_s_q;
    shadow_v_d   = shadow_v_q;
    result_d     = result_q;
    sample_out_d = sample_out_q;
    prod_d       = prod_q;
    wb_vld_d     = 1'b0;
    out_valid_d  = 1'b0;
    overflow_d   = 1'b0;
    missed_d     = bus.sample_strobe && (state_q != IDLE);

    if (wb_vld_q) begin
      result_d[pch_q] = sat;
      overflow_d      = clip;
    end

    case (state_q)
      IDLE: begin
        if (bus.sample_strobe) begin
          shadow_s_d = bus.sample_in;
          shadow_v_d = bus.vol_in;
          ch_d       = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        prod_d   = mul_a * mul_b;
        pch_d    = ch_q;
        wb_vld_d = 1'b1;
        if (ch_q == CW'(NCH-1)) begin
          ch_d    = '0;
          state_d = DRAIN;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        // result_q already holds the last channel, written on the DRAIN edge
        sample_out_d = result_q;
        out_valid_d  = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ch_q         <= '0;
      pch_q        <= '0;
      shadow_s_q   <= '0;
      shadow_v_q   <= '0;
      result_q     <= '0;
      sample_out_q <= '0;
      prod_q       <= '0;
      wb_vld_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      missed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      pch_q        <= pch_d;
      shadow_s_q   <= shadow_s_d;
      shadow_v_q   <= shadow_v_d;
      result_q     <= result_d;
      sample_out_q <= sample_out_d;
      prod_q       <= prod_d;
      wb_vld_q     <= wb_vld_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
      missed_q     <= missed_d;
    end
  end

  assign bus.sample_out = sample_out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy_q;
  assign bus.overflow   = overflow_q;
  assign bus.missed     = missed_q;
endmodule

// File: tb/tb_minimig_volume_scheduler.sv
// Directed bench for minimig_volume_scheduler: table of frames with hand-computed results,
// plus sequences for mid-frame reset, busy strobes and volume snapshotting.
module tb_minimig_volume_scheduler;
  localparam int NCH = 5;
  localparam int SW  = 16;
  localparam int VW  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  minimig_volume_scheduler_if #(.NCH(NCH), .SW(SW), .VW(VW)) bus ();
  minimig_volume_scheduler #(.NCH(NCH), .SW(SW), .VW(VW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [NCH-1:0][SW-1:0] s;
    logic [NCH-1:0][VW-1:0] v;
    logic [NCH-1:0][SW-1:0] exp;
    int                     ovf;
  } vec_t;

  vec_t tbl [5];
  int checks = 0;
  int errors = 0;

  int lat, nvalid, novf, nmissed, nbusy;
  logic [NCH*SW-1:0] data;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  // Pulse a strobe with s/v, then switch vol_in to v_after; optional extra strobe sampled at edge k2.
  task automatic run_frame(input logic [NCH*SW-1:0] s, input logic [NCH*VW-1:0] v,
                           input logic [NCH*VW-1:0] v_after, input int k2);
    @(negedge clk);
    bus.sample_strobe = 1'b1;
    bus.sample_in     = s;
    bus.vol_in        = v;
    @(posedge clk);
    #1;
    bus.sample_strobe = 1'b0;
    bus.vol_in        = v_after;
    lat = 0; nvalid = 0; novf = 0; nmissed = 0; nbusy = 0; data = '0;
    for (int k = 1; k <= 10; k++) begin
      bus.sample_strobe = (k == k2);
      @(posedge clk);
      #1;
      bus.sample_strobe = 1'b0;
      if (bus.out_valid) begin
        nvalid++;
        lat  = k;
        data = bus.sample_out;
      end
      novf    += int'(bus.overflow);
      nmissed += int'(bus.missed);
      nbusy   += int'(bus.busy);
    end
  endtask

  initial begin
    bus.sample_strobe = 1'b0;
    bus.sample_in     = '0;
    bus.vol_in        = '0;

    tbl[0].s = {16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h1234};
    tbl[0].v = {5{8'h80}};
    tbl[0].exp = {16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h1234};
    tbl[0].ovf = 0;
    tbl[1].s = {16'h0000, 16'h0000, 16'h4000, 16'h8000, 16'h7FFF};
    tbl[1].v = {5{8'hFF}};
    tbl[1].exp = {16'h0000, 16'h0000, 16'h7F80, 16'h8000, 16'h7FFF};
    tbl[1].ovf = 2;
    tbl[2].s = {16'h0000, 16'h0000, 16'h0100, 16'hFFFD, 16'h0003};
    tbl[2].v = {5{8'h40}};
    tbl[2].exp = {16'h0000, 16'h0000, 16'h0080, 16'hFFFE, 16'h0001};
    tbl[2].ovf = 0;
    tbl[3].s = {16'h8000, 16'h7FFF, 16'h1234, 16'hFFFF, 16'h8000};
    tbl[3].v = {5{8'h00}};
    tbl[3].exp = '0;
    tbl[3].ovf = 0;
    tbl[4].s = {16'hFFFF, 16'h0001, 16'hF000, 16'h1000, 16'h1000};
    tbl[4].v = {8'h01, 8'hFF, 8'hC0, 8'h40, 8'h80};
    tbl[4].exp = {16'hFFFF, 16'h0001, 16'hE800, 16'h0800, 16'h1000};
    tbl[4].ovf = 0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_missed", bus.missed, 0);
    chk("rst_sample_out", bus.sample_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset mid-RUN abandons the frame
    @(negedge clk);
    bus.sample_strobe = 1'b1;
    bus.sample_in     = tbl[0].s;
    bus.vol_in        = tbl[0].v;
    @(posedge clk);
    #1;
    bus.sample_strobe = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrun_busy_before", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrun_busy", bus.busy, 0);
    chk("midrun_sample_out", bus.sample_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nvalid = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      nvalid += int'(bus.out_valid);
    end
    chk("midrun_no_valid", nvalid, 0);
    chk("midrun_out_still0", bus.sample_out, 0);

    // table-driven frames
    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i].s, tbl[i].v, tbl[i].v, 0);
      chk($sformatf("vec%0d_nvalid", i), nvalid, 1);
      chk($sformatf("vec%0d_latency", i), lat, 7);
      chk($sformatf("vec%0d_data", i), data, tbl[i].exp);
      chk($sformatf("vec%0d_ovf", i), novf, tbl[i].ovf);
      chk($sformatf("vec%0d_missed", i), nmissed, 0);
    end
    chk("busy_cycles", nbusy, 6);
    chk("out_held", bus.sample_out, tbl[4].exp);

    // second strobe while running
    run_frame(tbl[0].s, tbl[0].v, tbl[0].v, 3);
    chk("busy_strobe_missed", nmissed, 1);
    chk("busy_strobe_nvalid", nvalid, 1);
    chk("busy_strobe_data", data, tbl[0].exp);

    // strobe sampled in the DONE state is dropped too
    run_frame(tbl[2].s, tbl[2].v, tbl[2].v, 7);
    chk("done_strobe_missed", nmissed, 1);
    chk("done_strobe_nvalid", nvalid, 1);
    chk("done_strobe_data", data, tbl[2].exp);

    // volume snapshot: change after the strobe edge has no effect on the frame
    run_frame(tbl[0].s, {5{8'h80}}, {5{8'h00}}, 0);
    chk("snap_data", data, tbl[0].exp);
    chk("snap_latency", lat, 7);
    run_frame(tbl[0].s, {5{8'h00}}, {5{8'h00}}, 0);
    chk("snap_next_data", data, 0);
    chk("snap_next_nvalid", nvalid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
